// File: rtl/stateful_rw_atom_pkg.sv
// Shared types and default widths for the stateful read/write atom.
package stateful_rw_atom_pkg;

    typedef enum logic [1:0] {
        MODE_WR_CONST = 2'd0,
        MODE_WR_PKT   = 2'd1,
        MODE_ADD_PKT  = 2'd2,
        MODE_READ     = 2'd3
    } mode_t;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_NUM_SLOTS  = 4;
    localparam int DEF_CNT_WIDTH  = 16;

endpackage

// File: rtl/stateful_rw_atom_rw_alu.sv
// Mode mux/adder: derives the post-update slot value and write enable.
module rw_alu
    import stateful_rw_atom_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] old_i,
    input  logic [DATA_WIDTH-1:0] const_i,
    input  logic [DATA_WIDTH-1:0] pkt_i,
    input  mode_t                 mode_i,
    output logic [DATA_WIDTH-1:0] new_o,
    output logic                  we_o
);

    always_comb begin
        new_o = old_i;
        we_o  = 1'b1;
        case (mode_i)
            MODE_WR_CONST: new_o = const_i;
            MODE_WR_PKT:   new_o = pkt_i;
            MODE_ADD_PKT:  new_o = old_i + pkt_i;
            default:       we_o  = 1'b0;
        endcase
    end

endmodule

// File: rtl/stateful_rw_atom.sv
// Two-stage slot-array read/modify/write atom with clear squash and saturating op counter.
module stateful_rw_atom
    import stateful_rw_atom_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_SLOTS  = DEF_NUM_SLOTS,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    localparam int IDX_WIDTH = $clog2(NUM_SLOTS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i__valid,
    input  logic [IDX_WIDTH-1:0]  i__idx,
    input  logic [1:0]            i__mode,
    input  logic [DATA_WIDTH-1:0] i__constant,
    input  logic [DATA_WIDTH-1:0] i__pkt_1,
    input  logic                  i__clear,
    output logic                  o__valid,
    output logic [IDX_WIDTH-1:0]  o__idx,
    output logic [DATA_WIDTH-1:0] o__old,
    output logic [DATA_WIDTH-1:0] o__new,
    output logic [CNT_WIDTH-1:0]  o__op_count
);

    logic                  vld_q;
    logic [IDX_WIDTH-1:0]  idx_q;
    mode_t                 mode_q;
    logic [DATA_WIDTH-1:0] const_q;
    logic [DATA_WIDTH-1:0] pkt_q;
    logic [DATA_WIDTH-1:0] slots_q [NUM_SLOTS];

    logic                  out_vld_q;
    logic [IDX_WIDTH-1:0]  out_idx_q;
    logic [DATA_WIDTH-1:0] out_old_q;
    logic [DATA_WIDTH-1:0] out_new_q;
    logic [CNT_WIDTH-1:0]  cnt_q;

    logic [DATA_WIDTH-1:0] old_d;
    logic [DATA_WIDTH-1:0] new_d;
    logic                  we_d;

    assign old_d = slots_q[idx_q];

    rw_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .old_i   (old_d),
        .const_i (const_q),
        .pkt_i   (pkt_q),
        .mode_i  (mode_q),
        .new_o   (new_d),
        .we_o    (we_d)
    );

    // Stage 1: operand capture; valid tracks every cycle, operands only on valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q   <= 1'b0;
            idx_q   <= '0;
            mode_q  <= MODE_WR_CONST;
            const_q <= '0;
            pkt_q   <= '0;
        end else begin
            vld_q <= i__valid;
            if (i__valid) begin
                idx_q   <= i__idx;
                mode_q  <= mode_t'(i__mode);
                const_q <= i__constant;
                pkt_q   <= i__pkt_1;
            end
        end
    end

    // Stage 2: the slot write lands on the same edge the next op is captured, so no bypass is needed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NUM_SLOTS; s++) slots_q[s] <= '0;
            out_vld_q <= 1'b0;
            out_idx_q <= '0;
            out_old_q <= '0;
            out_new_q <= '0;
            cnt_q     <= '0;
        end else if (i__clear) begin
            for (int s = 0; s < NUM_SLOTS; s++) slots_q[s] <= '0;
            out_vld_q <= 1'b0;
        end else begin
            out_vld_q <= vld_q;
            if (vld_q) begin
                if (we_d) slots_q[idx_q] <= new_d;
                out_idx_q <= idx_q;
                out_old_q <= old_d;
                out_new_q <= new_d;
                if (cnt_q != {CNT_WIDTH{1'b1}}) cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign o__valid    = out_vld_q;
    assign o__idx      = out_idx_q;
    assign o__old      = out_old_q;
    assign o__new      = out_new_q;
    assign o__op_count = cnt_q;

endmodule

// File: tb/tb_stateful_rw_atom.sv
// Scoreboard bench: a wide-counter instance plus a 4-bit-counter instance share all stimulus.
module tb_stateful_rw_atom;

    localparam int DW = 8;
    localparam int NS = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i__valid = 1'b0;
    logic [IW-1:0] i__idx = '0;
    logic [1:0]    i__mode = '0;
    logic [DW-1:0] i__constant = '0;
    logic [DW-1:0] i__pkt_1 = '0;
    logic          i__clear = 1'b0;

    logic          o__valid, s__valid;
    logic [IW-1:0] o__idx, s__idx;
    logic [DW-1:0] o__old, o__new, s__old, s__new;
    logic [15:0]   o__op_count;
    logic [3:0]    s__op_count;

    always #5 clk = ~clk;

    stateful_rw_atom #(.DATA_WIDTH(DW), .NUM_SLOTS(NS), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .i__valid(i__valid), .i__idx(i__idx), .i__mode(i__mode),
        .i__constant(i__constant), .i__pkt_1(i__pkt_1), .i__clear(i__clear),
        .o__valid(o__valid), .o__idx(o__idx), .o__old(o__old), .o__new(o__new),
        .o__op_count(o__op_count)
    );

    stateful_rw_atom #(.DATA_WIDTH(DW), .NUM_SLOTS(NS), .CNT_WIDTH(4)) dut_sat (
        .clk(clk), .rst(rst), .i__valid(i__valid), .i__idx(i__idx), .i__mode(i__mode),
        .i__constant(i__constant), .i__pkt_1(i__pkt_1), .i__clear(i__clear),
        .o__valid(s__valid), .o__idx(s__idx), .o__old(s__old), .o__new(s__new),
        .o__op_count(s__op_count)
    );

    typedef struct {
        int          due;
        logic [1:0]  idx;
        logic [7:0]  old_v;
        logic [7:0]  new_v;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  model[NS];
    logic [15:0] exp_cnt;
    int          cyc;
    int          nvec;
    int          nfail;

    function automatic logic [3:0] sat4(input logic [15:0] c);
        return (c > 16'd15) ? 4'hF : c[3:0];
    endfunction

    task automatic model_reset();
        sb.delete();
        for (int s = 0; s < NS; s++) model[s] = '0;
        exp_cnt = '0;
    endtask

    // Drive one cycle of stimulus, advance one edge, then compare outputs.
    task automatic step(input logic v, input logic [1:0] idx, input logic [1:0] mode,
                        input logic [7:0] cst, input logic [7:0] pkt, input logic clr);
        exp_t e;
        i__valid = v; i__idx = idx; i__mode = mode;
        i__constant = cst; i__pkt_1 = pkt; i__clear = clr;
        if (clr) begin
            for (int s = 0; s < NS; s++) model[s] = '0;
            while (sb.size() > 0 && sb[sb.size()-1].due == cyc + 1) void'(sb.pop_back());
        end
        if (v) begin
            e.due = cyc + 2; e.idx = idx; e.old_v = model[idx];
            case (mode)
                2'd0: e.new_v = cst;
                2'd1: e.new_v = pkt;
                2'd2: e.new_v = model[idx] + pkt;
                default: e.new_v = model[idx];
            endcase
            model[idx] = e.new_v;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        cyc++;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 1'b1;
            nvec++;
            if (o__valid !== 1'b1 || o__idx !== e.idx || o__old !== e.old_v || o__new !== e.new_v) begin
                nfail++;
                $display("FAIL result cyc=%0d got v=%b idx=%0d old=%h new=%h want v=1 idx=%0d old=%h new=%h",
                         cyc, o__valid, o__idx, o__old, o__new, e.idx, e.old_v, e.new_v);
            end
        end else begin
            nvec++;
            if (o__valid !== 1'b0) begin
                nfail++;
                $display("FAIL idle_valid cyc=%0d got %b want 0", cyc, o__valid);
            end
        end
        nvec++;
        if (o__op_count !== exp_cnt || s__op_count !== sat4(exp_cnt)) begin
            nfail++;
            $display("FAIL op_count cyc=%0d got %h/%h want %h/%h",
                     cyc, o__op_count, s__op_count, exp_cnt, sat4(exp_cnt));
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i__valid = 1'b0; i__clear = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        model_reset();
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        // Ops presented while rst is high must be dropped.
        rst = 1'b1;
        i__valid = 1'b1; i__idx = 2'd1; i__mode = 2'd1; i__pkt_1 = 8'hAA;
        repeat (2) @(posedge clk);
        #1;
        nvec++;
        if (o__valid !== 1'b0 || o__old !== 8'h00 || o__new !== 8'h00 || o__idx !== 2'd0 || o__op_count !== 16'h0) begin
            nfail++;
            $display("FAIL reset_state got v=%b idx=%0d old=%h new=%h cnt=%h want all 0",
                     o__valid, o__idx, o__old, o__new, o__op_count);
        end
        i__valid = 1'b0;
        do_reset();
        idle(3);
        for (int s = 0; s < NS; s++) step(1'b1, s[1:0], 2'd3, 8'h00, 8'h00, 1'b0);
        idle(2);
    endtask

    task automatic test_wr_pkt();
        step(1'b1, 2'd2, 2'd1, 8'h00, 8'h5A, 1'b0);
        idle(3);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) step(1'b1, 2'd1, 2'd2, 8'h00, 8'hF0, 1'b0);
        idle(3);
    endtask

    task automatic test_const_read();
        step(1'b1, 2'd0, 2'd0, 8'h33, 8'h77, 1'b0);
        step(1'b1, 2'd0, 2'd3, 8'h00, 8'h00, 1'b0);
        for (int s = 0; s < NS; s++) step(1'b1, s[1:0], 2'd3, 8'h99, 8'h99, 1'b0);
        idle(3);
    endtask

    task automatic test_clear();
        step(1'b1, 2'd3, 2'd1, 8'h00, 8'h11, 1'b0);
        step(1'b1, 2'd3, 2'd3, 8'h00, 8'h00, 1'b1);
        idle(3);
        // Mixed random traffic with an occasional clear.
        for (int k = 0; k < 24; k++)
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 8'($urandom), 8'($urandom), ($urandom_range(0, 7) == 0));
        idle(3);
    endtask

    task automatic test_async_reset();
        step(1'b1, 2'd2, 2'd1, 8'h00, 8'hC3, 1'b0);
        step(1'b0, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0);
        i__valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        nvec++;
        if (o__valid !== 1'b0 || o__old !== 8'h00 || o__new !== 8'h00 || o__idx !== 2'd0 || o__op_count !== 16'h0) begin
            nfail++;
            $display("FAIL async_reset got v=%b idx=%0d old=%h new=%h cnt=%h want all 0",
                     o__valid, o__idx, o__old, o__new, o__op_count);
        end
        do_reset();
        idle(2);
        step(1'b1, 2'd2, 2'd3, 8'h00, 8'h00, 1'b0);
        idle(3);
    endtask

    task automatic test_saturate();
        do_reset();
        for (int k = 0; k < 20; k++) step(1'b1, k[1:0], 2'd2, 8'h00, 8'h01, 1'b0);
        idle(3);
        nvec++;
        if (s__op_count !== 4'hF || o__op_count !== 16'd20) begin
            nfail++;
            $display("FAIL saturate got %h/%0d want F/20", s__op_count, o__op_count);
        end
    endtask

    initial begin
        nvec = 0; nfail = 0; cyc = 0;
        model_reset();
        test_reset();
        test_wr_pkt();
        test_back_to_back();
        test_const_read();
        test_clear();
        test_async_reset();
        test_saturate();
        if (sb.size() != 0) begin
            nvec++; nfail++;
            $display("FAIL drain got %0d pending want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/stateful_rw_atom.md
Name: stateful_rw_atom

Overview:
- Parametrised successor to the single-register read/write atom.
- Holds NUM_SLOTS state registers of DATA_WIDTH bits. Each valid packet selects one slot by index and applies a mode: write constant, write packet field, add packet field, or read-only.
- Returns the pre-update and post-update values to the packet pipeline two cycles after issue.
- Sits in the stateful stage of the packet-transaction pipeline, one instance per stateful variable array.

Parameters:
- DATA_WIDTH, 8, width of each state slot, constant and packet operand.
- NUM_SLOTS, 4, number of state slots (power of two, >=2).
- IDX_WIDTH, $clog2(NUM_SLOTS), slot index width (derived, not overridden).
- CNT_WIDTH, 16, width of the saturating operation counter.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- i__valid  input  1  packet operation present this cycle
- i__idx  input  IDX_WIDTH  target slot
- i__mode  input  2  0=WR_CONST, 1=WR_PKT, 2=ADD_PKT, 3=READ
- i__constant  input  DATA_WIDTH  configured constant for WR_CONST
- i__pkt_1  input  DATA_WIDTH  packet field operand
- i__clear  input  1  zero all slots
- o__valid  output  1  result valid
- o__idx  output  IDX_WIDTH  slot of result
- o__old  output  DATA_WIDTH  slot value before update
- o__new  output  DATA_WIDTH  slot value after update
- o__op_count  output  CNT_WIDTH  completed (non-squashed) operations, saturating

Behaviour:
- Reset (asynchronous, rst=1):
  - All slots 0.
  - Stage-1 valid 0.
  - o__valid 0; o__idx, o__old, o__new 0.
  - o__op_count 0.
  - Holds while rst is high; operations presented during reset are dropped.
- Always ready; no backpressure. One operation accepted per cycle.
- Stage 1 (edge t+1): capture i__valid, i__idx, i__mode, i__constant, i__pkt_1. Operand registers update only when i__valid=1; the valid register updates every cycle.
- Stage 2 (during cycle t+1, committed at edge t+2):
  - old = slot[idx_q].
  - new is mode-dependent:
    - WR_CONST: new = constant_q.
    - WR_PKT: new = pkt_q.
    - ADD_PKT: new = (old + pkt_q) mod 2^DATA_WIDTH, wraps, no saturation.
    - READ: new = old, no write.
  - At edge t+2: slot[idx_q] <= new; o__valid <= 1; o__idx, o__old, o__new registered.
- Latency: exactly 2 cycles from i__valid to o__valid.
- o__idx, o__old, o__new hold their last values when o__valid=0.
- Back-to-back operations to the same slot need no bypass: the stage-2 write lands at the same edge the next operation is captured, so that operation reads the updated value. Verify this explicitly.
- o__op_count increments on every o__valid=1 edge (READ included) and saturates at all-ones.
- i__clear at cycle t:
  - At edge t+1, all slots <= 0.
  - Any stage-2 operation committing at that edge is squashed: no slot write, o__valid <= 0, no count increment.
  - An operation presented in the same cycle t is still captured and executes in cycle t+1 against the zeroed slots.
- Clear does not reset o__op_count or the output data registers.

Decomposition:
- Package stateful_rw_atom_pkg:
  - typedef enum logic [1:0] mode_t {MODE_WR_CONST, MODE_WR_PKT, MODE_ADD_PKT, MODE_READ}.
  - Default width constants.
- Sub-module rw_alu: combinational mode mux/adder (old, constant, pkt, mode -> new, we). It is the direct generalisation of the existing two-way write mux.
- Slot array, pipeline registers and counter stay in the top module.

Test Plan:
- Reset then idle → o__valid=0, o__op_count=0, all READs of slots 0..3 return old=new=0.
- WR_PKT idx=2 pkt=0x5A at t → at t+2: o__valid=1, o__idx=2, old=0x00, new=0x5A; count=1.
- ADD_PKT idx=1 pkt=0xF0 on three consecutive cycles (back-to-back, same slot) → new=0xF0, 0xE0 (wrap), 0xD0; old=0x00, 0xF0, 0xE0.
- WR_CONST idx=0 constant=0x33, then READ idx=0 → second result old=new=0x33; other slots unchanged.
- WR_PKT idx=3 pkt=0x11 at t, i__clear at t+1 → op squashed: o__valid=0 at t+2, count unchanged. A READ idx=3 issued at t+1 returns old=new=0x00 at t+3.
- Assert rst mid-stream while o__valid=1 → outputs drop to 0 immediately (asynchronously). Force o__op_count near all-ones (CNT_WIDTH=4, 16 operations) → count holds at 0xF.
